// File: rtl/multicycle_control_fsm.sv
// Multi-cycle RV32I main controller: sequences fetch/decode/execute/memory/writeback and drives datapath enables.
// Optional performance counters (cycle_count, instret) are built when CTRL_PERF_CNT_EN is defined.
module multicycle_control_fsm #(
  parameter int MEM_TIMEOUT = 0,
  parameter int STATE_W     = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [6:0]         Opcode,
  input  logic               branch_taken,
  input  logic               mem_ready,
  output logic               PCWrite,
  output logic               IRWrite,
  output logic               AdrSrc,
  output logic               MemRead,
  output logic               MemWrite,
  output logic               RegWrite,
  output logic [1:0]         ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [1:0]         ALUOp,
  output logic [1:0]         ResultSrc,
  output logic [2:0]         ImmSrc,
  output logic [STATE_W-1:0] state,
  output logic               illegal
`ifdef CTRL_PERF_CNT_EN
  ,
  output logic [31:0]        cycle_count,
  output logic [31:0]        instret
`endif
);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECR    = 4'd6,
    EXECI    = 4'd7,
    ALUWB    = 4'd8,
    BRANCH   = 4'd9,
    JAL      = 4'd10,
    JALR     = 4'd11,
    UPPER    = 4'd12,
    TRAP     = 4'd13
  } state_t;

  state_t      r_state;
  state_t      w_nextState;
  logic [31:0] r_waitCnt;
  logic        r_illegal;
  logic        w_waiting;
  logic        w_timeout;

  // A wait cycle is any cycle spent in a memory-handshake state without mem_ready.
  assign w_waiting = !mem_ready &&
                     ((r_state == FETCH) || (r_state == MEMREAD) || (r_state == MEMWRITE));
  assign w_timeout = (MEM_TIMEOUT != 0) && w_waiting &&
                     (r_waitCnt == 32'(MEM_TIMEOUT - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= FETCH;
      r_waitCnt <= '0;
      r_illegal <= 1'b0;
    end else begin
      r_state   <= w_nextState;
      r_waitCnt <= ((MEM_TIMEOUT != 0) && w_waiting && !w_timeout) ? r_waitCnt + 32'd1 : '0;
      r_illegal <= r_illegal | (w_nextState == TRAP);
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      FETCH:    if (mem_ready) w_nextState = DECODE;
      DECODE: begin
        case (Opcode)
          OP_LOAD, OP_STORE: w_nextState = MEMADR;
          OP_RTYPE:          w_nextState = EXECR;
          OP_ITYPE:          w_nextState = EXECI;
          OP_BRANCH:         w_nextState = BRANCH;
          OP_JAL:            w_nextState = JAL;
          OP_JALR:           w_nextState = JALR;
          OP_LUI, OP_AUIPC:  w_nextState = UPPER;
          default:           w_nextState = TRAP;
        endcase
      end
      MEMADR:   w_nextState = (Opcode == OP_LOAD) ? MEMREAD : MEMWRITE;
      MEMREAD:  if (mem_ready) w_nextState = MEMWB;
      MEMWB:    w_nextState = FETCH;
      MEMWRITE: if (mem_ready) w_nextState = FETCH;
      EXECR:    w_nextState = ALUWB;
      EXECI:    w_nextState = ALUWB;
      ALUWB:    w_nextState = FETCH;
      BRANCH:   w_nextState = FETCH;
      JAL:      w_nextState = ALUWB;
      JALR:     w_nextState = ALUWB;
      UPPER:    w_nextState = ALUWB;
      TRAP:     w_nextState = TRAP;
      default:  w_nextState = TRAP;
    endcase
    if (w_timeout) w_nextState = TRAP;
  end

  // Outputs are forced inactive while reset is held so no request or write escapes.
  always_comb begin
    PCWrite   = 1'b0;
    IRWrite   = 1'b0;
    AdrSrc    = 1'b0;
    MemRead   = 1'b0;
    MemWrite  = 1'b0;
    RegWrite  = 1'b0;
    ALUSrcA   = 2'd0;
    ALUSrcB   = 2'd0;
    ALUOp     = 2'd0;
    ResultSrc = 2'd0;
    ImmSrc    = 3'd0;
    if (!reset) begin
      case (Opcode)
        OP_STORE:         ImmSrc = 3'd1;
        OP_BRANCH:        ImmSrc = 3'd2;
        OP_LUI, OP_AUIPC: ImmSrc = 3'd3;
        OP_JAL:           ImmSrc = 3'd4;
        default:          ImmSrc = 3'd0;
      endcase
      case (r_state)
        FETCH: begin
          MemRead = 1'b1;
          ALUSrcB = 2'd2;
          if (mem_ready) begin
            IRWrite   = 1'b1;
            PCWrite   = 1'b1;
            ResultSrc = 2'd2;
          end
        end
        DECODE: begin
          ALUSrcA = 2'd1;
          ALUSrcB = 2'd1;
        end
        MEMADR: begin
          ALUSrcA = 2'd2;
          ALUSrcB = 2'd1;
        end
        MEMREAD: begin
          MemRead = 1'b1;
          AdrSrc  = 1'b1;
        end
        MEMWB: begin
          ResultSrc = 2'd1;
          RegWrite  = 1'b1;
        end
        MEMWRITE: begin
          MemWrite = 1'b1;
          AdrSrc   = 1'b1;
        end
        EXECR: begin
          ALUSrcA = 2'd2;
          ALUOp   = 2'd2;
        end
        EXECI: begin
          ALUSrcA = 2'd2;
          ALUSrcB = 2'd1;
          ALUOp   = 2'd2;
        end
        ALUWB:    RegWrite = 1'b1;
        BRANCH: begin
          ALUSrcA = 2'd2;
          ALUOp   = 2'd1;
          PCWrite = branch_taken;
        end
        JAL: begin
          ALUSrcA = 2'd1;
          ALUSrcB = 2'd2;
          PCWrite = 1'b1;
        end
        JALR: begin
          ALUSrcA   = 2'd2;
          ALUSrcB   = 2'd1;
          ResultSrc = 2'd2;
          PCWrite   = 1'b1;
        end
        UPPER: begin
          ALUSrcA = (Opcode == OP_AUIPC) ? 2'd1 : 2'd2;
          ALUSrcB = 2'd1;
        end
        default: ;
      endcase
    end
  end

  assign state   = STATE_W'(r_state);
  assign illegal = r_illegal;

`ifdef CTRL_PERF_CNT_EN
  logic [31:0] r_cycleCount;
  logic [31:0] r_instret;
  logic        w_retire;

  // An instruction retires on the last step back to FETCH from a terminal state.
  assign w_retire = (w_nextState == FETCH) &&
                    ((r_state == MEMWB) || (r_state == MEMWRITE) ||
                     (r_state == ALUWB) || (r_state == BRANCH));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cycleCount <= '0;
      r_instret    <= '0;
    end else begin
      r_cycleCount <= r_cycleCount + 32'd1;
      if (w_retire) r_instret <= r_instret + 32'd1;
    end
  end

  assign cycle_count = r_cycleCount;
  assign instret     = r_instret;
`endif

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Scoreboard bench for multicycle_control_fsm: directed per-cycle vectors with hand-written expected controls.
module tb_multicycle_control_fsm;

  typedef struct packed {
    logic [3:0] st;
    logic       pcw;
    logic       irw;
    logic       adr;
    logic       mrd;
    logic       mwr;
    logic       rw;
    logic [1:0] srcA;
    logic [1:0] srcB;
    logic [1:0] aluOp;
    logic [1:0] res;
    logic [2:0] imm;
    logic       ill;
  } ctrl_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [6:0] Opcode = 7'b0010011;
  logic       branch_taken = 1'b0;
  logic       mem_ready = 1'b0;
  logic       PCWrite, IRWrite, AdrSrc, MemRead, MemWrite, RegWrite;
  logic [1:0] ALUSrcA, ALUSrcB, ALUOp, ResultSrc;
  logic [2:0] ImmSrc;
  logic [3:0] state;
  logic       illegal;
`ifdef CTRL_PERF_CNT_EN
  logic [31:0] cycle_count, instret;
`endif

  ctrl_t expQ[$];
  string nameQ[$];
  int    checks = 0;
  int    errors = 0;

  localparam logic [6:0] LOAD = 7'b0000011, STORE = 7'b0100011, RTYP = 7'b0110011;
  localparam logic [6:0] ITYP = 7'b0010011, BR = 7'b1100011, JALO = 7'b1101111;
  localparam logic [6:0] JALRO = 7'b1100111, LUI = 7'b0110111, AUIPC = 7'b0010111;
  localparam logic [6:0] BAD = 7'b1111111;

  multicycle_control_fsm #(.MEM_TIMEOUT(8), .STATE_W(4)) dut (
    .clk(clk), .reset(reset), .Opcode(Opcode), .branch_taken(branch_taken),
    .mem_ready(mem_ready), .PCWrite(PCWrite), .IRWrite(IRWrite), .AdrSrc(AdrSrc),
    .MemRead(MemRead), .MemWrite(MemWrite), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .ResultSrc(ResultSrc), .ImmSrc(ImmSrc),
    .state(state), .illegal(illegal)
`ifdef CTRL_PERF_CNT_EN
    , .cycle_count(cycle_count), .instret(instret)
`endif
  );

  always #5 clk = ~clk;

  function automatic ctrl_t mk(int st, int pcw, int irw, int adr, int mrd, int mwr, int rw,
                               int a, int b, int op, int res, int imm, int ill);
    ctrl_t c;
    c.st = 4'(st);   c.pcw = 1'(pcw); c.irw = 1'(irw); c.adr = 1'(adr);
    c.mrd = 1'(mrd); c.mwr = 1'(mwr); c.rw = 1'(rw);   c.srcA = 2'(a);
    c.srcB = 2'(b);  c.aluOp = 2'(op); c.res = 2'(res); c.imm = 3'(imm);
    c.ill = 1'(ill);
    return c;
  endfunction

  // Drive one cycle of inputs at the falling edge and queue what that cycle must show.
  task automatic applyStimulus(input string name, input logic rst, input logic [6:0] opc,
                               input logic tk, input logic rdy, input ctrl_t exp);
    @(negedge clk);
    reset = rst;
    Opcode = opc;
    branch_taken = tk;
    mem_ready = rdy;
    expQ.push_back(exp);
    nameQ.push_back(name);
  endtask

  task automatic checkOutput(input string name, input ctrl_t exp);
    ctrl_t act;
    act = '{state, PCWrite, IRWrite, AdrSrc, MemRead, MemWrite, RegWrite,
            ALUSrcA, ALUSrcB, ALUOp, ResultSrc, ImmSrc, illegal};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: compare each queued expectation shortly after the inputs for that cycle settle.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (expQ.size() > 0) checkOutput(nameQ.pop_front(), expQ.pop_front());
    end
  end

  initial begin
    ctrl_t fetchIdle, decodeV, aluwb, trapV, idle;
    fetchIdle = mk(0, 0,0,0,1,0,0, 0,2,0,0, 0,0);
    decodeV   = mk(1, 0,0,0,0,0,0, 1,1,0,0, 0,0);
    aluwb     = mk(8, 0,0,0,0,0,1, 0,0,0,0, 0,0);
    trapV     = mk(13,0,0,0,0,0,0, 0,0,0,0, 0,1);
    idle      = mk(0, 0,0,0,0,0,0, 0,0,0,0, 0,0);

    applyStimulus("reset0", 1, ITYP, 0, 1, idle);
    applyStimulus("reset1", 1, STORE, 0, 1, idle);

    applyStimulus("addi_fetch",  0, ITYP, 0, 1, mk(0,1,1,0,1,0,0, 0,2,0,2, 0,0));
    applyStimulus("addi_decode", 0, ITYP, 0, 0, decodeV);
    applyStimulus("addi_execi",  0, ITYP, 0, 0, mk(7,0,0,0,0,0,0, 2,1,2,0, 0,0));
    applyStimulus("addi_aluwb",  0, ITYP, 0, 0, aluwb);

    applyStimulus("lw_fetch_wait", 0, LOAD, 0, 0, fetchIdle);
    applyStimulus("lw_fetch",      0, LOAD, 0, 1, mk(0,1,1,0,1,0,0, 0,2,0,2, 0,0));
    applyStimulus("lw_decode",     0, LOAD, 0, 1, decodeV);
    applyStimulus("lw_memadr",     0, LOAD, 0, 1, mk(2,0,0,0,0,0,0, 2,1,0,0, 0,0));
    for (int i = 0; i < 3; i++)
      applyStimulus("lw_memread_wait", 0, LOAD, 0, 0, mk(3,0,0,1,1,0,0, 0,0,0,0, 0,0));
    applyStimulus("lw_memread_done", 0, LOAD, 0, 1, mk(3,0,0,1,1,0,0, 0,0,0,0, 0,0));
    applyStimulus("lw_memwb",        0, LOAD, 0, 0, mk(4,0,0,0,0,0,1, 0,0,0,1, 0,0));

    applyStimulus("beq_fetch",  0, BR, 1, 1, mk(0,1,1,0,1,0,0, 0,2,0,2, 2,0));
    applyStimulus("beq_decode", 0, BR, 1, 0, mk(1,0,0,0,0,0,0, 1,1,0,0, 2,0));
    applyStimulus("beq_taken",  0, BR, 1, 0, mk(9,1,0,0,0,0,0, 2,0,1,0, 2,0));
    applyStimulus("bne_fetch",  0, BR, 0, 1, mk(0,1,1,0,1,0,0, 0,2,0,2, 2,0));
    applyStimulus("bne_decode", 0, BR, 0, 0, mk(1,0,0,0,0,0,0, 1,1,0,0, 2,0));
    applyStimulus("bne_not",    0, BR, 0, 1, mk(9,0,0,0,0,0,0, 2,0,1,0, 2,0));

    applyStimulus("sw_fetch",    0, STORE, 0, 1, mk(0,1,1,0,1,0,0, 0,2,0,2, 1,0));
    applyStimulus("sw_decode",   0, STORE, 0, 0, mk(1,0,0,0,0,0,0, 1,1,0,0, 1,0));
    applyStimulus("sw_memadr",   0, STORE, 0, 0, mk(2,0,0,0,0,0,0, 2,1,0,0, 1,0));
    applyStimulus("sw_memwrite", 0, STORE, 0, 1, mk(5,0,0,1,0,1,0, 0,0,0,0, 1,0));

    applyStimulus("jal_fetch",  0, JALO, 0, 1, mk(0,1,1,0,1,0,0, 0,2,0,2, 4,0));
    applyStimulus("jal_decode", 0, JALO, 0, 0, mk(1,0,0,0,0,0,0, 1,1,0,0, 4,0));
    applyStimulus("jal_jal",    0, JALO, 0, 0, mk(10,1,0,0,0,0,0, 1,2,0,0, 4,0));
    applyStimulus("jal_aluwb",  0, JALO, 0, 0, mk(8,0,0,0,0,0,1, 0,0,0,0, 4,0));

    applyStimulus("jalr_fetch",  0, JALRO, 0, 1, mk(0,1,1,0,1,0,0, 0,2,0,2, 0,0));
    applyStimulus("jalr_decode", 0, JALRO, 0, 0, decodeV);
    applyStimulus("jalr_jalr",   0, JALRO, 0, 0, mk(11,1,0,0,0,0,0, 2,1,0,2, 0,0));
    applyStimulus("jalr_aluwb",  0, JALRO, 0, 0, aluwb);

    applyStimulus("lui_fetch",  0, LUI, 0, 1, mk(0,1,1,0,1,0,0, 0,2,0,2, 3,0));
    applyStimulus("lui_decode", 0, LUI, 0, 0, mk(1,0,0,0,0,0,0, 1,1,0,0, 3,0));
    applyStimulus("lui_upper",  0, LUI, 0, 0, mk(12,0,0,0,0,0,0, 2,1,0,0, 3,0));
    applyStimulus("lui_aluwb",  0, LUI, 0, 0, mk(8,0,0,0,0,0,1, 0,0,0,0, 3,0));
    applyStimulus("auipc_fetch",  0, AUIPC, 0, 1, mk(0,1,1,0,1,0,0, 0,2,0,2, 3,0));
    applyStimulus("auipc_decode", 0, AUIPC, 0, 0, mk(1,0,0,0,0,0,0, 1,1,0,0, 3,0));
    applyStimulus("auipc_upper",  0, AUIPC, 0, 0, mk(12,0,0,0,0,0,0, 1,1,0,0, 3,0));
    applyStimulus("auipc_aluwb",  0, AUIPC, 0, 0, mk(8,0,0,0,0,0,1, 0,0,0,0, 3,0));

    applyStimulus("add_fetch",  0, RTYP, 0, 1, mk(0,1,1,0,1,0,0, 0,2,0,2, 0,0));
    applyStimulus("add_decode", 0, RTYP, 0, 1, decodeV);
    applyStimulus("add_execr",  0, RTYP, 0, 1, mk(6,0,0,0,0,0,0, 2,0,2,0, 0,0));
    applyStimulus("add_aluwb",  0, RTYP, 0, 1, aluwb);

    applyStimulus("swr_fetch",   0, STORE, 0, 1, mk(0,1,1,0,1,0,0, 0,2,0,2, 1,0));
    applyStimulus("swr_decode",  0, STORE, 0, 0, mk(1,0,0,0,0,0,0, 1,1,0,0, 1,0));
    applyStimulus("swr_memadr",  0, STORE, 0, 0, mk(2,0,0,0,0,0,0, 2,1,0,0, 1,0));
    applyStimulus("swr_wait",    0, STORE, 0, 0, mk(5,0,0,1,0,1,0, 0,0,0,0, 1,0));
    applyStimulus("swr_reset",   1, STORE, 0, 0, idle);
    applyStimulus("swr_release", 0, ITYP, 0, 0, fetchIdle);

    applyStimulus("bad_fetch",  0, BAD, 0, 1, mk(0,1,1,0,1,0,0, 0,2,0,2, 0,0));
    applyStimulus("bad_decode", 0, BAD, 0, 0, decodeV);
    for (int i = 0; i < 10; i++)
      applyStimulus("trap_hold", 0, BAD, 0, i[0], trapV);
    applyStimulus("trap_reset", 1, STORE, 0, 0, idle);

    for (int i = 0; i < 8; i++)
      applyStimulus("tmo_wait", 0, LOAD, 0, 0, fetchIdle);
    applyStimulus("tmo_trap",  0, LOAD, 0, 0, trapV);
    applyStimulus("tmo_stays", 0, LOAD, 0, 1, trapV);

    for (int i = 0; i < 5 && expQ.size() > 0; i++) @(negedge clk);
    #4;
    checks++;
    if (expQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain: got %0d pending, expected 0", expQ.size());
    end
`ifdef CTRL_PERF_CNT_EN
    checks++;
    if (instret !== 32'd0) begin
      errors++;
      $display("[TB] FAIL instret_after_timeout: got %0d, expected 0", instret);
    end
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
